// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multi-cycle sequencer for the Mini-MIPS core. Steps each
//            instruction through FETCH, DECODE, EXEC, (FP_WAIT), (MEM), WB
//            and drives the IR/PC/data-memory/FP/register-file enables.
//            Every handshake wait is bounded by WAIT_LIMIT cycles; an expired
//            wait halts the core with a sticky error.
// Ports    : clk, reset (async, active-low), run
//            imem_ready, dmem_ready, fp_done         - handshake inputs
//            reg_write..fp_op, halt_instr           - decoded controls (DECODE)
//            alu_zero                               - ALU flag (EXEC)
//            imem_req, ir_load, pc_write, pc_src    - fetch / PC control
//            dmem_req, dmem_we, fp_start            - data memory / FP control
//            rf_write_enable, wb_sel                - write-back control
//            state, halted, error, instr_count      - status
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             reg_write,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             mem_to_reg,
   input  logic             branch,
   input  logic             branch_type,
   input  logic             jump,
   input  logic             jr_control,
   input  logic             fp_op,
   input  logic             halt_instr,
   input  logic             alu_zero,
   input  logic             fp_done,
   output logic             imem_req,
   output logic             ir_load,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             fp_start,
   output logic             rf_write_enable,
   output logic             wb_sel,
   output logic [2:0]       state,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXEC    = 3'd3,
      S_FP_WAIT = 3'd4,
      S_MEM     = 3'd5,
      S_WB      = 3'd6,
      S_HALT    = 3'd7
   } state_e;

   localparam int                WAIT_W    = $clog2(WAIT_LIMIT + 1);
   // Value of the wait counter during the WAIT_LIMIT-th cycle of a wait.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   // Controls latched in DECODE, consumed by EXEC/FP_WAIT/MEM/WB.
   logic               rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, m2r_q, m2r_d;
   logic               br_q, br_d, bt_q, bt_d, fp_q, fp_d;

   logic               retire;
   logic               timeout;
   logic               waiting;
   state_e             boundary;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rw_q    <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         m2r_q   <= 1'b0;
         br_q    <= 1'b0;
         bt_q    <= 1'b0;
         fp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rw_q    <= rw_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         m2r_q   <= m2r_d;
         br_q    <= br_d;
         bt_q    <= bt_d;
         fp_q    <= fp_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rw_d     = rw_q;
      mr_d     = mr_q;
      mw_d     = mw_q;
      m2r_d    = m2r_q;
      br_d     = br_q;
      bt_d     = bt_q;
      fp_d     = fp_q;
      retire   = 1'b0;
      timeout  = 1'b0;
      ir_load  = 1'b0;
      pc_write = 1'b0;
      pc_src   = 2'b00;
      fp_start = 1'b0;
      boundary = run ? S_FETCH : S_IDLE;

      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            // Ready takes priority over an expiring wait.
            if (imem_ready) begin
               ir_load  = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               timeout = 1'b1;
               state_d = S_HALT;
            end
         end
         S_DECODE: begin
            rw_d  = reg_write;
            mr_d  = mem_read;
            mw_d  = mem_write;
            m2r_d = mem_to_reg;
            br_d  = branch;
            bt_d  = branch_type;
            fp_d  = fp_op;
            if (halt_instr) begin
               state_d = S_HALT;
            end else if (jr_control || jump) begin
               pc_write = 1'b1;
               pc_src   = jr_control ? 2'b11 : 2'b10;
               retire   = 1'b1;
               state_d  = boundary;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (fp_q) begin
               fp_start = 1'b1;
               state_d  = S_FP_WAIT;
            end else if (br_q) begin
               // branch_type flips the sense: 0 = beq, 1 = bne.
               if (alu_zero ^ bt_q) begin
                  pc_write = 1'b1;
                  pc_src   = 2'b01;
               end
               retire  = 1'b1;
               state_d = boundary;
            end else if (mr_q || mw_q) begin
               state_d = S_MEM;
            end else if (rw_q) begin
               state_d = S_WB;
            end else begin
               retire  = 1'b1;
               state_d = boundary;
            end
         end
         S_FP_WAIT: begin
            if (fp_done) begin
               if (rw_q) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = boundary;
               end
            end else if (wait_q == WAIT_LAST) begin
               timeout = 1'b1;
               state_d = S_HALT;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (mr_q) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = boundary;
               end
            end else if (wait_q == WAIT_LAST) begin
               timeout = 1'b1;
               state_d = S_HALT;
            end
         end
         S_WB: begin
            retire  = 1'b1;
            state_d = boundary;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase

      // Any state change (including entry into a wait state) clears the
      // counter; it only advances while a wait state holds.
      waiting = (state_q == S_FETCH) || (state_q == S_MEM) || (state_q == S_FP_WAIT);
      wait_d  = (waiting && (state_d == state_q)) ? (wait_q + WAIT_W'(1)) : '0;
      err_d   = err_q | timeout;
      cnt_d   = cnt_q + (retire ? CNT_W'(1) : CNT_W'(0));
   end

   assign state           = state_q;
   assign imem_req        = (state_q == S_FETCH);
   assign dmem_req        = (state_q == S_MEM);
   assign dmem_we         = (state_q == S_MEM) & mw_q;
   assign rf_write_enable = (state_q == S_WB);
   assign wb_sel          = (state_q == S_WB) & m2r_q;
   assign halted          = (state_q == S_HALT);
   assign error           = err_q;
   assign instr_count     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed bench for multicycle_controller. Each step pushes the
//            expected output bundle and instruction count into scoreboard
//            queues, then pops and compares them against the DUT mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             run;
   logic             imem_ready, dmem_ready;
   logic             reg_write, mem_read, mem_write, mem_to_reg;
   logic             branch, branch_type, jump, jr_control, fp_op;
   logic             halt_instr, alu_zero, fp_done;
   logic             imem_req, ir_load, pc_write, dmem_req, dmem_we;
   logic             fp_start, rf_write_enable, wb_sel, halted, error;
   logic [1:0]       pc_src;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_count;

   int n_checks = 0;
   int n_err    = 0;

   // Bundle: {state, imem_req, ir_load, pc_write, pc_src, dmem_req, dmem_we,
   //          fp_start, rf_write_enable, wb_sel, halted, error}
   logic [14:0]      sb_q[$];
   logic [CNT_W-1:0] cnt_q[$];

   always #5 clk = ~clk;

   multicycle_controller #(.WAIT_LIMIT(16), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .run(run),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .branch(branch), .branch_type(branch_type),
      .jump(jump), .jr_control(jr_control), .fp_op(fp_op),
      .halt_instr(halt_instr), .alu_zero(alu_zero), .fp_done(fp_done),
      .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write),
      .pc_src(pc_src), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .fp_start(fp_start), .rf_write_enable(rf_write_enable),
      .wb_sel(wb_sel), .state(state), .halted(halted), .error(error),
      .instr_count(instr_count)
   );

   task automatic clr_ctl();
      imem_ready = 0; dmem_ready = 0; reg_write = 0; mem_read = 0;
      mem_write = 0; mem_to_reg = 0; branch = 0; branch_type = 0;
      jump = 0; jr_control = 0; fp_op = 0; halt_instr = 0;
      alu_zero = 0; fp_done = 0;
   endtask

   // Request/strobe bits that follow directly from the state are filled in
   // from the state code; the rest are given explicitly.
   task automatic push_exp(input logic [2:0] st, input logic irl,
                           input logic pcw, input logic [1:0] pcs,
                           input logic dwe, input logic fps, input logic wbs,
                           input logic err, input logic [CNT_W-1:0] cnt);
      sb_q.push_back({st, st == 3'd1, irl, pcw, pcs, st == 3'd5, dwe, fps,
                      st == 3'd6, wbs, st == 3'd7, err});
      cnt_q.push_back(cnt);
   endtask

   task automatic check(input string tag);
      logic [14:0]      obs, exp;
      logic [CNT_W-1:0] ecnt;
      obs  = {state, imem_req, ir_load, pc_write, pc_src, dmem_req, dmem_we,
              fp_start, rf_write_enable, wb_sel, halted, error};
      exp  = sb_q.pop_front();
      ecnt = cnt_q.pop_front();
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
      end
      n_checks++;
      assert (instr_count === ecnt) else begin
         n_err++;
         $error("FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, ecnt);
      end
   endtask

   // Called just after a rising edge: compare at the falling edge, then move
   // on to just after the next rising edge.
   task automatic step(input string tag, input logic [2:0] st, input logic irl,
                       input logic pcw, input logic [1:0] pcs, input logic dwe,
                       input logic fps, input logic wbs, input logic err,
                       input logic [CNT_W-1:0] cnt);
      push_exp(st, irl, pcw, pcs, dwe, fps, wbs, err, cnt);
      @(negedge clk);
      check(tag);
      @(posedge clk); #1;
   endtask

   task automatic plain(input string tag, input logic [2:0] st,
                        input logic err, input logic [CNT_W-1:0] cnt);
      step(tag, st, 0, 0, 2'b00, 0, 0, 0, err, cnt);
   endtask

   task automatic fetch_hit(input string tag, input logic [CNT_W-1:0] cnt);
      imem_ready = 1;
      step(tag, 3'd1, 1, 1, 2'b00, 0, 0, 0, 0, cnt);
      imem_ready = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0; run = 0; clr_ctl();
      repeat (2) @(posedge clk); #1;
      plain("reset", 3'd0, 0, 0);
      reset = 1; run = 1;
      plain("idle_run", 3'd0, 0, 0);

      // R-type with reg_write
      fetch_hit("rtype_fetch", 0);
      reg_write = 1;
      plain("rtype_decode", 3'd2, 0, 0);
      clr_ctl();
      plain("rtype_exec", 3'd3, 0, 0);
      step("rtype_wb", 3'd6, 0, 0, 2'b00, 0, 0, 0, 0, 0);

      // lw, dmem_ready on the third MEM cycle
      fetch_hit("lw_fetch", 1);
      mem_read = 1; mem_to_reg = 1;
      plain("lw_decode", 3'd2, 0, 1);
      clr_ctl();
      plain("lw_exec", 3'd3, 0, 1);
      plain("lw_mem1", 3'd5, 0, 1);
      plain("lw_mem2", 3'd5, 0, 1);
      dmem_ready = 1;
      plain("lw_mem3", 3'd5, 0, 1);
      dmem_ready = 0;
      step("lw_wb", 3'd6, 0, 0, 2'b00, 0, 0, 1, 0, 1);

      // sw: immediate dmem_ready, no WB
      fetch_hit("sw_fetch", 2);
      mem_write = 1;
      plain("sw_decode", 3'd2, 0, 2);
      clr_ctl();
      plain("sw_exec", 3'd3, 0, 2);
      dmem_ready = 1;
      step("sw_mem", 3'd5, 0, 0, 2'b00, 1, 0, 0, 0, 2);
      dmem_ready = 0;

      // beq taken
      fetch_hit("beq_fetch", 3);
      branch = 1; branch_type = 0;
      plain("beq_decode", 3'd2, 0, 3);
      clr_ctl(); alu_zero = 1;
      step("beq_exec", 3'd3, 0, 1, 2'b01, 0, 0, 0, 0, 3);
      alu_zero = 0;

      // bne not taken when alu_zero = 1
      fetch_hit("bne_fetch", 4);
      branch = 1; branch_type = 1;
      plain("bne_decode", 3'd2, 0, 4);
      clr_ctl(); alu_zero = 1;
      plain("bne_exec", 3'd3, 0, 4);
      alu_zero = 0;

      // jr and jump together: jr wins
      fetch_hit("jr_fetch", 5);
      jr_control = 1; jump = 1;
      step("jr_decode", 3'd2, 0, 1, 2'b11, 0, 0, 0, 0, 5);
      clr_ctl();
      fetch_hit("j_fetch", 6);
      jump = 1;
      step("j_decode", 3'd2, 0, 1, 2'b10, 0, 0, 0, 0, 6);
      clr_ctl();

      // FP op, fp_done on the 5th FP_WAIT cycle; stray readies ignored
      fetch_hit("fp_fetch", 7);
      fp_op = 1; reg_write = 1;
      plain("fp_decode", 3'd2, 0, 7);
      clr_ctl();
      step("fp_exec", 3'd3, 0, 0, 2'b00, 0, 1, 0, 0, 7);
      imem_ready = 1; dmem_ready = 1;
      for (int i = 1; i <= 5; i++) begin
         if (i == 5) fp_done = 1;
         plain($sformatf("fp_wait%0d", i), 3'd4, 0, 7);
      end
      clr_ctl(); run = 0;
      step("fp_wb", 3'd6, 0, 0, 2'b00, 0, 0, 0, 0, 7);
      plain("idle_stop", 3'd0, 0, 8);
      run = 1;
      plain("idle_restart", 3'd0, 0, 8);

      // MEM timeout after two FETCH wait cycles
      plain("to_fetch_w1", 3'd1, 0, 8);
      plain("to_fetch_w2", 3'd1, 0, 8);
      fetch_hit("to_fetch", 8);
      mem_read = 1;
      plain("to_decode", 3'd2, 0, 8);
      clr_ctl();
      plain("to_exec", 3'd3, 0, 8);
      for (int i = 1; i <= 16; i++) plain($sformatf("to_mem%0d", i), 3'd5, 0, 8);
      plain("to_halt", 3'd7, 1, 8);
      imem_ready = 1;
      plain("to_halt_stay", 3'd7, 1, 8);
      clr_ctl();

      // Leave HALT via reset, then reset asynchronously in the middle of MEM
      reset = 0;
      plain("rst_from_halt", 3'd0, 0, 0);
      reset = 1;
      plain("rst_idle", 3'd0, 0, 0);
      fetch_hit("rm_fetch", 0);
      mem_write = 1;
      plain("rm_decode", 3'd2, 0, 0);
      clr_ctl();
      plain("rm_exec", 3'd3, 0, 0);
      step("rm_mem1", 3'd5, 0, 0, 2'b00, 1, 0, 0, 0, 0);
      reset = 0;
      #1;
      push_exp(3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      check("rm_async_reset");
      @(posedge clk); #1;
      dmem_ready = 1;
      plain("rm_reset_hold", 3'd0, 0, 0);
      dmem_ready = 0;
      reset = 1;
      plain("rm_idle", 3'd0, 0, 0);

      // Ready on the 16th FETCH cycle beats the timeout; then halt_instr
      for (int i = 1; i <= 15; i++) plain($sformatf("lim_fetch%0d", i), 3'd1, 0, 0);
      fetch_hit("lim_fetch16", 0);
      halt_instr = 1;
      plain("halt_decode", 3'd2, 0, 0);
      clr_ctl();
      plain("halt_state", 3'd7, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
